// File: rtl/inst_mem_responder_if.sv
// rtl/inst_mem_responder_if.sv - fetch request/response handshake bundle for the instruction memory responder
interface inst_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pc;
  logic [31:0] resp_inst;
  logic        resp_err;

  // fetch stage side
  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_pc, resp_inst, resp_err
  );

  // memory responder side
  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_pc, resp_inst, resp_err
  );
endinterface

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction RAM with fixed-latency read pipeline, in-order response FIFO and flush
module inst_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_mem_responder_if.slave   bus,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]           mem_q [2**DEPTH_LOG2];

  logic [LAT-1:0]        stg_valid_q, stg_valid_d;
  logic [31:0]           stg_pc_q   [LAT];
  logic [31:0]           stg_inst_q [LAT];
  logic [LAT-1:0]        stg_err_q;

  logic [31:0]           fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]           fifo_inst_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_err_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;

  logic [CW-1:0]         inflight;
  logic                  accept, pop, push, nonempty, acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;

  assign acc_idx = bus.req_addr[DEPTH_LOG2+1:2];
  assign acc_err = (bus.req_addr[1:0] != 2'b00) | (bus.req_addr[31:DEPTH_LOG2+2] != '0);

  // count pipeline stages holding a live fetch
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(stg_valid_q[i]);
    end
  end

  // credits cover pipeline plus FIFO, so a pushed entry always has a slot
  assign bus.req_ready  = rst_n & ~flush & ((CW'(count_q) + inflight) < DEPTH_C);
  assign nonempty       = rst_n & (count_q != '0);
  assign bus.resp_valid = nonempty & ~flush;
  assign bus.resp_pc    = nonempty ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign bus.resp_inst  = nonempty ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign bus.resp_err   = nonempty & fifo_err_q[rd_ptr_q];

  assign accept = bus.req_valid & bus.req_ready;
  assign pop    = bus.resp_valid & bus.resp_ready;
  assign push   = stg_valid_q[LAT-1] & ~flush;

  // next-state for pipeline valids and FIFO bookkeeping; flush wipes everything
  always_comb begin
    stg_valid_d    = '0;
    stg_valid_d[0] = accept;
    for (int i = 1; i < LAT; i++) begin
      stg_valid_d[i] = stg_valid_q[i-1];
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    if (flush) begin
      stg_valid_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end
  end

  // control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // read-first RAM access at accept time, then shift the payload down the pipeline
  always_ff @(posedge clk) begin
    stg_pc_q[0]   <= bus.req_addr;
    stg_err_q[0]  <= acc_err;
    stg_inst_q[0] <= acc_err ? NOP : mem_q[acc_idx];
    for (int i = 1; i < LAT; i++) begin
      stg_pc_q[i]   <= stg_pc_q[i-1];
      stg_err_q[i]  <= stg_err_q[i-1];
      stg_inst_q[i] <= stg_inst_q[i-1];
    end
  end

  // response FIFO payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= stg_pc_q[LAT-1];
      fifo_inst_q[wr_ptr_q] <= stg_inst_q[LAT-1];
      fifo_err_q[wr_ptr_q]  <= stg_err_q[LAT-1];
    end
  end

  // loader write port, independent of flush and the fetch side
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - randomized and directed self-checking bench for inst_mem_responder
module tb_inst_mem_responder;
  localparam int DL  = 10;
  localparam int LAT = 2;
  localparam int FD  = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    int          due;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [31:0]   wr_data;

  inst_mem_responder_if bus();

  inst_mem_responder #(.DEPTH_LOG2(DL), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  logic [31:0] mmem [1 << DL];
  ent_t        pend[$];
  ent_t        mfifo[$];
  ent_t        lit[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic drive(logic rv, logic [31:0] addr, logic rr, logic fl, logic rs,
                       logic we, logic [DL-1:0] wa, logic [31:0] wd);
    bus.req_valid  = rv;
    bus.req_addr   = addr;
    bus.resp_ready = rr;
    flush          = fl;
    rst_n          = rs;
    wr_en          = we;
    wr_addr        = wa;
    wr_data        = wd;
    #1;
  endtask

  // model state advance at one clock edge, from the rules only
  task automatic model_edge();
    ent_t e;
    bit   rdy;
    bit   vld;
    if (!rst_n || flush) begin
      pend.delete();
      mfifo.delete();
    end else begin
      rdy = (pend.size() + mfifo.size()) < FD;
      vld = mfifo.size() != 0;
      if (vld && bus.resp_ready) void'(mfifo.pop_front());
      while (pend.size() != 0 && pend[0].due == edge_n) begin
        e = pend.pop_front();
        mfifo.push_back(e);
      end
      if (bus.req_valid && rdy) begin
        e.pc   = bus.req_addr;
        e.err  = (bus.req_addr[1:0] != 0) || (bus.req_addr[31:DL+2] != 0);
        e.inst = e.err ? 32'h13 : mmem[bus.req_addr[DL+1:2]];
        e.due  = edge_n + LAT;
        pend.push_back(e);
      end
    end
    if (wr_en) mmem[wr_addr] = wr_data;
    edge_n++;
  endtask

  // compare all outputs against the model, then advance one clock
  task automatic tick();
    bit          e_rdy;
    bit          e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_err;
    e_rdy  = rst_n && !flush && ((pend.size() + mfifo.size()) < FD);
    e_vld  = rst_n && !flush && (mfifo.size() != 0);
    e_pc   = 0;
    e_inst = 0;
    e_err  = 0;
    if (rst_n && mfifo.size() != 0) begin
      e_pc   = mfifo[0].pc;
      e_inst = mfifo[0].inst;
      e_err  = mfifo[0].err;
    end
    chk("req_ready",  bus.req_ready,  e_rdy);
    chk("resp_valid", bus.resp_valid, e_vld);
    chk("resp_pc",    bus.resp_pc,    e_pc);
    chk("resp_inst",  bus.resp_inst,  e_inst);
    chk("resp_err",   bus.resp_err,   e_err);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic lit_push(logic [31:0] pc, logic [31:0] inst, logic err);
    ent_t e;
    e.pc = pc; e.inst = inst; e.err = err; e.due = 0;
    lit.push_back(e);
  endtask

  // idle with resp_ready=1 and match every response against the literal list
  task automatic collect(int budget, output int first);
    ent_t l;
    first = -1;
    for (int i = 0; i < budget; i++) begin
      drive(0, 0, 1, 0, 1, 0, 0, 0);
      if (bus.resp_valid) begin
        if (first < 0) first = i;
        if (lit.size() == 0) begin
          chk("no_extra_resp", bus.resp_valid, 0);
        end else begin
          l = lit.pop_front();
          chk("lit_pc",   bus.resp_pc,   l.pc);
          chk("lit_inst", bus.resp_inst, l.inst);
          chk("lit_err",  bus.resp_err,  l.err);
        end
      end
      tick();
    end
    chk("lit_missing", lit.size(), 0);
    lit.delete();
  endtask

  logic [31:0] addrs2 [6];
  logic [31:0] vals   [4];
  int          first;
  int          acc;
  logic [31:0] a;

  initial begin
    addrs2[0] = 32'h0; addrs2[1] = 32'h4; addrs2[2] = 32'h8;
    addrs2[3] = 32'hC; addrs2[4] = 32'h0; addrs2[5] = 32'h4;
    vals[0] = 32'h11111111; vals[1] = 32'h22222222;
    vals[2] = 32'h33333333; vals[3] = 32'h44444444;

    // reset
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      chk("rst_req_ready",  bus.req_ready,  0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      tick();
    end
    drive(0, 0, 1, 0, 1, 0, 0, 0);
    chk("post_rst_ready", bus.req_ready, 1);
    tick();

    // preload words 0..3
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 1, 1, DL'(i), vals[i]);
      tick();
    end

    // single read at LAT latency
    drive(1, 32'h8, 1, 0, 1, 0, 0, 0);
    chk("t1_ready", bus.req_ready, 1);
    tick();
    lit_push(32'h8, 32'h33333333, 0);
    collect(6, first);
    chk("t1_latency", first, LAT);

    // credit limit with resp_ready low, then drain in order
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, addrs2[k], 0, 0, 1, 0, 0, 0);
      if (bus.req_ready) acc++;
      tick();
    end
    chk("t2_accepted", acc, 4);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      chk("t2_full_ready", bus.req_ready, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 1, 0, 0, 0);
      if (k == 1) chk("t2_ready_after_pop", bus.req_ready, 1);
      chk("t2_valid", bus.resp_valid, 1);
      chk("t2_inst",  bus.resp_inst,  vals[k]);
      tick();
    end
    drive(0, 0, 1, 0, 1, 0, 0, 0);
    chk("t2_drained", bus.resp_valid, 0);
    tick();

    // misaligned and out-of-range requests
    drive(1, 32'h6, 1, 0, 1, 0, 0, 0);
    tick();
    drive(1, 32'h1000, 1, 0, 1, 0, 0, 0);
    tick();
    lit_push(32'h6, 32'h13, 1);
    lit_push(32'h1000, 32'h13, 1);
    collect(8, first);

    // flush kills three in-flight requests
    drive(1, 32'h0, 1, 0, 1, 0, 0, 0); tick();
    drive(1, 32'h8, 1, 0, 1, 0, 0, 0); tick();
    drive(1, 32'hC, 1, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 1, 0, 0, 0);
    chk("t4_flush_valid", bus.resp_valid, 0);
    chk("t4_flush_ready", bus.req_ready,  0);
    tick();
    collect(8, first);
    drive(1, 32'h4, 1, 0, 1, 0, 0, 0);
    chk("t4_ready_after", bus.req_ready, 1);
    tick();
    lit_push(32'h4, 32'h22222222, 0);
    collect(6, first);
    chk("t4_latency", first, LAT);

    // read-first collision, then new data
    drive(1, 32'h4, 1, 0, 1, 1, DL'(1), 32'hDEADBEEF);
    tick();
    lit_push(32'h4, 32'h22222222, 0);
    collect(6, first);
    drive(1, 32'h4, 1, 0, 1, 0, 0, 0);
    tick();
    lit_push(32'h4, 32'hDEADBEEF, 0);
    collect(6, first);

    // reset with 2 buffered and 1 in flight
    drive(1, 32'h0, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 32'h8, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 32'hC, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);     tick();
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("t6_valid", bus.resp_valid, 0);
    chk("t6_pc",    bus.resp_pc,    0);
    chk("t6_inst",  bus.resp_inst,  0);
    chk("t6_err",   bus.resp_err,   0);
    chk("t6_ready", bus.req_ready,  0);
    tick();
    drive(0, 0, 1, 0, 1, 0, 0, 0);
    chk("t6_ready_after", bus.req_ready,  1);
    chk("t6_valid_after", bus.resp_valid, 0);
    tick();
    collect(8, first);

    // randomized traffic over preloaded words 0..63
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 1, 0, 1, 1, DL'(i), $urandom);
      tick();
    end
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = {24'h0, $urandom_range(0, 63) * 4 + $urandom_range(1, 3)};
        1:       a = 32'h0000_1000 | (32'($urandom_range(0, 255)) << 12) | 32'($urandom_range(0, 63) * 4);
        default: a = 32'($urandom_range(0, 63) * 4);
      endcase
      drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0,
            $urandom_range(0, 9) == 0, DL'($urandom_range(0, 63)), $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
